// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and taken
// control-transfer hazards, data-memory handshake with timeout, and
// saturating stall/flush event counters. State updates on the falling edge.
module pipeline_hazard_controller #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned MEM_TIMEOUT = 200
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IFID_rs1,
   input  logic [4:0]       IFID_rs2,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_rd,
   input  logic             EXMEM_Branch,
   input  logic             EXMEM_Zero,
   input  logic             EXMEM_Jal,
   input  logic             EXMEM_MemRead,
   input  logic             EXMEM_MemWrite,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             PCWrite,
   output logic             IFID_Write,
   output logic             IDEX_Write,
   output logic             EXMEM_Write,
   output logic             PCSrc,
   output logic             IFID_Flush,
   output logic             IDEX_Flush,
   output logic             EXMEM_Flush,
   output logic             mem_error,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_ERROR
   } state_t;

   state_t          state, stateNext;
   logic [TO_W-1:0] toCnt, toNext;
   logic            stallInc, flushInc, errSet;
   logic            memOp, take, loadUse;

   assign memOp   = EXMEM_MemRead | EXMEM_MemWrite;
   assign take    = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal;
   assign loadUse = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                    ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

   // Next-state, counter events and pipeline controls; controls forced low during reset
   always_comb begin
      stateNext   = state;
      toNext      = toCnt;
      stallInc    = 1'b0;
      flushInc    = 1'b0;
      errSet      = 1'b0;
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      PCSrc       = 1'b0;
      IFID_Flush  = 1'b0;
      IDEX_Flush  = 1'b0;
      EXMEM_Flush = 1'b0;
      unique case (state)
         ST_RUN: begin
            if (memOp && !mem_ready) begin
               mem_req   = 1'b1;
               stateNext = ST_MEM_WAIT;
               toNext    = TO_W'(1);
               stallInc  = 1'b1;
            end else begin
               mem_req = memOp;
               if (take) begin
                  PCSrc       = 1'b1;
                  IFID_Flush  = 1'b1;
                  IDEX_Flush  = 1'b1;
                  EXMEM_Flush = 1'b1;
                  PCWrite     = 1'b1;
                  IFID_Write  = 1'b1;
                  IDEX_Write  = 1'b1;
                  EXMEM_Write = 1'b1;
                  flushInc    = 1'b1;
               end else if (loadUse) begin
                  IDEX_Flush  = 1'b1;
                  IDEX_Write  = 1'b1;
                  EXMEM_Write = 1'b1;
                  stallInc    = 1'b1;
               end else begin
                  PCWrite     = 1'b1;
                  IFID_Write  = 1'b1;
                  IDEX_Write  = 1'b1;
                  EXMEM_Write = 1'b1;
               end
            end
         end
         ST_MEM_WAIT: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               stateNext = ST_RUN;
            end else begin
               stallInc = 1'b1;
               if (toCnt == TO_W'(MEM_TIMEOUT)) begin
                  stateNext = ST_ERROR;
                  errSet    = 1'b1;
               end else begin
                  toNext = toCnt + TO_W'(1);
               end
            end
         end
         ST_ERROR: begin
            stallInc = 1'b1;
         end
         default: begin
            stateNext = ST_RUN;
         end
      endcase
      if (!reset) begin
         mem_req     = 1'b0;
         PCWrite     = 1'b0;
         IFID_Write  = 1'b0;
         IDEX_Write  = 1'b0;
         EXMEM_Write = 1'b0;
         PCSrc       = 1'b0;
         IFID_Flush  = 1'b0;
         IDEX_Flush  = 1'b0;
         EXMEM_Flush = 1'b0;
      end
   end

   // FSM state, timeout counter, sticky error and saturating event counters
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         toCnt       <= '0;
         mem_error   <= 1'b0;
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         state <= stateNext;
         toCnt <= toNext;
         if (errSet)
            mem_error <= 1'b1;
         if (stallInc && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
         if (flushInc && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: the driver predicts each
// cycle's outputs from a behavioural model and queues them; a monitor pops
// and compares against the DUT.
module tb_pipeline_hazard_controller;

   localparam int CNT_W = 3;
   localparam int TO_W = 8;
   localparam int MEM_TIMEOUT = 4;
   localparam int SAT = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [4:0] IFID_rs1 = '0, IFID_rs2 = '0, IDEX_rd = '0;
   logic IDEX_MemRead = 1'b0, EXMEM_Branch = 1'b0, EXMEM_Zero = 1'b0, EXMEM_Jal = 1'b0;
   logic EXMEM_MemRead = 1'b0, EXMEM_MemWrite = 1'b0, mem_ready = 1'b0;
   logic mem_req, PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, PCSrc;
   logic IFID_Flush, IDEX_Flush, EXMEM_Flush, mem_error;
   logic [CNT_W-1:0] stall_count, flush_count;

   pipeline_hazard_controller #(
      .CNT_W(CNT_W),
      .TO_W(TO_W),
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
      .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
      .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero), .EXMEM_Jal(EXMEM_Jal),
      .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
      .mem_ready(mem_ready), .mem_req(mem_req),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
      .EXMEM_Write(EXMEM_Write), .PCSrc(PCSrc),
      .IFID_Flush(IFID_Flush), .IDEX_Flush(IDEX_Flush), .EXMEM_Flush(EXMEM_Flush),
      .mem_error(mem_error), .stall_count(stall_count), .flush_count(flush_count)
   );

   // DUT acts on the falling edge; bench drives on rising edge, samples at +3
   always #5 clk = ~clk;

   logic [15:0] expQ[$];
   int total = 0;
   int bad = 0;
   int cycleNo = 0;

   // Reference model: mode 0 = running, 1 = waiting on memory, 2 = hung
   int mode = 0;
   int waitLow = 0;
   int stalls = 0;
   int flushes = 0;

   task automatic cyc(input bit rs, input int r1, input int r2, input bit mr, input int rd,
                      input bit br, input bit z, input bit jl, input bit er, input bit ew,
                      input bit rdy);
      bit mq, pw, iw, dw, xw, ps, ifl, dfl, xfl, me, memOp, tk, lu;
      logic [2:0] sc, fc;
      @(posedge clk);
      reset = rs;
      IFID_rs1 = r1[4:0]; IFID_rs2 = r2[4:0]; IDEX_MemRead = mr; IDEX_rd = rd[4:0];
      EXMEM_Branch = br; EXMEM_Zero = z; EXMEM_Jal = jl;
      EXMEM_MemRead = er; EXMEM_MemWrite = ew; mem_ready = rdy;
      #1;
      {mq, pw, iw, dw, xw, ps, ifl, dfl, xfl, me} = '0;
      memOp = er | ew;
      tk = (br && z) || jl;
      lu = mr && (rd != 0) && ((rd == r1) || (rd == r2));
      if (!rs) begin
         mode = 0; waitLow = 0; stalls = 0; flushes = 0;
      end else if (mode == 0) begin
         if (memOp && !rdy) mq = 1;
         else begin
            mq = memOp;
            if (tk) {pw, iw, dw, xw, ps, ifl, dfl, xfl} = '1;
            else if (lu) begin dw = 1; xw = 1; dfl = 1; end
            else {pw, iw, dw, xw} = '1;
         end
      end else if (mode == 1) mq = 1;
      else me = 1;
      sc = 3'(stalls);
      fc = 3'(flushes);
      expQ.push_back({mq, pw, iw, dw, xw, ps, ifl, dfl, xfl, me, sc, fc});
      if (rs) begin
         if (mode == 0) begin
            if (memOp && !rdy) begin
               mode = 1; waitLow = 0; stalls = (stalls < SAT) ? stalls + 1 : SAT;
            end else if (tk) flushes = (flushes < SAT) ? flushes + 1 : SAT;
            else if (lu) stalls = (stalls < SAT) ? stalls + 1 : SAT;
         end else if (mode == 1) begin
            if (rdy) mode = 0;
            else begin
               stalls = (stalls < SAT) ? stalls + 1 : SAT;
               waitLow++;
               if (waitLow == MEM_TIMEOUT) mode = 2;
            end
         end else stalls = (stalls < SAT) ? stalls + 1 : SAT;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: compare each cycle's DUT outputs with the queued prediction
   initial begin
      logic [15:0] e, a;
      forever begin
         @(posedge clk);
         #3;
         cycleNo++;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            a = {mem_req, PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, PCSrc,
                 IFID_Flush, IDEX_Flush, EXMEM_Flush, mem_error, stall_count, flush_count};
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL outputs cycle %0d: got=%b expected=%b (req,pcw,ifw,idw,exw,pcsrc,iff,idf,exf,err,stall3,flush3)",
                        cycleNo, a, e);
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      // load-use, then x0 destination
      cyc(1, 0, 5, 1, 5, 0, 0, 0, 0, 0, 0);
      idle(1);
      cyc(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      // taken branch with simultaneous load-use, then not-taken
      cyc(1, 0, 5, 1, 5, 1, 1, 0, 0, 0, 0);
      idle(1);
      cyc(1, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0);
      idle(1);
      // jal with a completing memory op
      cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1);
      idle(1);
      // memory wait: 3 cycles not ready, then ready, then op retired
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      idle(2);
      // stalled memory beats a branch; reset abandons the access
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
      idle(1);
      // timeout into the hung state, then reset out of it
      for (int i = 0; i < 8; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      // counter saturation
      for (int i = 0; i < 10; i++) cyc(1, 3, 0, 1, 3, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      idle(1);
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 99) != 0,
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 9) < 7);
      end
      repeat (3) @(posedge clk);
      #4;
      if (expQ.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard drain: got=%0d pending expected=0", expQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
